inst_fetch_unit: RTL and testbench
==================================

# inst_fetch_unit

Instruction fetch stage sitting directly upstream of the single-cycle core datapath: it generates sequential fetch addresses, issues requests to instruction memory over a request/grant/response handshake, and buffers returned words with their PCs in a small FIFO. The core consumes `{instr, instr_pc}` with a valid/ready handshake and steers fetch with a redirect (taken branch/jump target). Stale responses after a redirect are discarded.

## Interface
- `n`, 32, data/address width
- `DEPTH`, 4, FIFO entries (power of two, ≥2)
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk` in 1 — rising-edge clock
- `areset` in 1 — reset, synchronous, active-high
- `redirect` in 1 — flush and restart fetch at `redirect_pc`
- `redirect_pc` in n — new fetch address
- `mem_req` out 1 — fetch request valid
- `mem_addr` out n — fetch address (word aligned)
- `mem_gnt` in 1 — request accepted this cycle
- `mem_rvalid` in 1 — response data valid
- `mem_rdata` in n — fetched instruction word
- `instr_valid` out 1 — FIFO head valid
- `instr` out n — head instruction
- `instr_pc` out n — head PC
- `instr_ready` in 1 — core pops head
- `fetch_fault` out 1 — misaligned redirect flag (only with macro)

## Operation
- FSM: IDLE (nothing outstanding), REQ (`mem_req`=1, awaiting grant), WAIT (granted, awaiting `mem_rvalid`). At most one request outstanding.
- IDLE→REQ when `count + 0 < DEPTH`; REQ→WAIT on `mem_gnt`; WAIT→REQ on `mem_rvalid` if space remains after the write, else WAIT→IDLE.
- `mem_addr` and `mem_req` held stable from assertion until `mem_gnt`; redirect never changes a pending request.
- On grant: `fetch_pc <= fetch_pc + 4` (mod 2^n wrap, no overflow flag).
- On `mem_rvalid` with `discard`=0: push `{mem_rdata, req_pc}`. With `discard`=1: drop word, clear `discard`.
- Pop when `instr_valid && instr_ready`. Push and pop in the same cycle keep `count` unchanged; push into full FIFO cannot occur (space reserved at request time).
- Redirect: FIFO emptied, `fetch_pc <= redirect_pc`, `discard <= 1` if state is REQ or WAIT; pop ignored that cycle. Redirect has priority over push/pop. Redirect in same cycle as `mem_rvalid`: word dropped, `discard` not set.
- `mem_rvalid` in IDLE/REQ is a protocol error; ignored.
- Reset mid-operation: FSM→IDLE, FIFO empty, `discard`=0, `fetch_pc`=RESET_PC; any in-flight response after reset ignored.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=RESET_PC, `instr_valid`=0, `instr`=0, `instr_pc`=0, `fetch_fault`=0.
- First cycle after reset deasserts: IDLE; `mem_req`=1 the following cycle.
- `mem_rvalid` at cycle t → `instr_valid`=1 at t+1 (registered FIFO). Earliest rvalid is one cycle after grant.
- Back-to-back: grant at t, rvalid at t+1, next `mem_req` at t+2 → sustained 1 instr / 2 cycles with zero-latency memory.
- Redirect at t → `instr_valid`=0 at t+1.

## Configuration
- `IFU_MISALIGN_CHECK_EN` defined: redirect with `redirect_pc[1:0]!=0` sets sticky `fetch_fault`, flushes, and halts fetch (IDLE, no requests) until next aligned redirect or reset, which clears it.
- Undefined: `fetch_fault` tied 0; `redirect_pc[1:0]` forced to 0.

## Structure
- Package `ifu_pkg`: FSM state enum (IDLE/REQ/WAIT), FIFO entry struct `{pc, instr}`, default `RESET_PC`.
- Sub-module `ifu_fifo`: synchronous DEPTH-entry FIFO with count, flush, push/pop; FSM and handshake in the top.

## Test plan
- Reset, `mem_gnt`=1 always, rvalid one cycle after grant with rdata=addr^32'hA5A5_0000, ready=1 → `instr_pc` sequence 0,4,8,12 with matching `instr`.
- `instr_ready`=0 → exactly DEPTH=4 entries fill, `mem_req` stays 0 afterward; ready=1 drains in order 0..12.
- Grant delayed 3 cycles → `mem_addr` constant during wait; redirect to 0x100 during REQ → granted word at old address discarded, next `instr_pc`=0x100.
- Redirect same cycle as rvalid → that word never appears; next output PC = `redirect_pc`.
- `fetch_pc`=0xFFFF_FFFC → next request address 0x0000_0000.
- With macro: redirect to 0x102 → `fetch_fault`=1, no `mem_req`; redirect to 0x200 → fault cleared, fetch resumes at 0x200.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types for the instruction fetch unit: FSM state, FIFO entry layout and the
// default fetch start address.
package ifu_pkg;

   localparam int unsigned IfuXlen = 32;

   localparam logic [IfuXlen-1:0] ResetPcDefault = 32'h0000_0000;

   // StIdle: nothing outstanding; StReq: request held until grant; StWait: awaiting response
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StWait = 2'd2
   } ifu_state_e;

   typedef struct packed {
      logic [IfuXlen-1:0] pc;
      logic [IfuXlen-1:0] instr;
   } ifu_entry_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Memory-side request/grant/response bus and core-side instruction valid/ready bus of the
// fetch unit. The master modport is the fetch unit; the slave modport is memory plus core.
interface inst_fetch_unit_if #(
   parameter int unsigned n = 32
);

   logic         mem_req;
   logic [n-1:0] mem_addr;
   logic         mem_gnt;
   logic         mem_rvalid;
   logic [n-1:0] mem_rdata;

   logic         instr_valid;
   logic [n-1:0] instr;
   logic [n-1:0] instr_pc;
   logic         instr_ready;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_gnt,
      input  mem_rvalid,
      input  mem_rdata,
      output instr_valid,
      output instr,
      output instr_pc,
      input  instr_ready
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_gnt,
      output mem_rvalid,
      output mem_rdata,
      input  instr_valid,
      input  instr,
      input  instr_pc,
      output instr_ready
   );

endinterface

// File: rtl/ifu_fifo.sv
// Synchronous DEPTH-entry FIFO of {pc, instr} entries with occupancy count and flush.
// The head is presented combinationally from storage and reads as zero while empty.
module ifu_fifo
   import ifu_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PtrW = $clog2(DEPTH),
   localparam int unsigned CntW = PtrW + 1
) (
   input  logic            clk,
   input  logic            areset,
   input  logic            flush,
   input  logic            push,
   input  ifu_entry_t      wdata,
   input  logic            pop,
   output ifu_entry_t      rdata,
   output logic            valid,
   output logic [CntW-1:0] count
);

   ifu_entry_t      mem_q [DEPTH];
   logic [PtrW-1:0] wptr_q;
   logic [PtrW-1:0] rptr_q;
   logic [CntW-1:0] count_q;
   logic            do_push;
   logic            do_pop;

   // Flush overrides both push and pop; popping an empty FIFO is ignored
   assign do_push = push && !flush;
   assign do_pop  = pop && !flush && (count_q != '0);

   // Entry storage, written at the tail
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wptr_q] <= wdata;
      end
   end

   // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
   always_ff @(posedge clk) begin
      if (areset || flush) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            wptr_q <= wptr_q + 1'b1;
         end
         if (do_pop) begin
            rptr_q <= rptr_q + 1'b1;
         end
         count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
      end
   end

   assign valid = (count_q != '0);
   assign rdata = valid ? mem_q[rptr_q] : '0;
   assign count = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches over a req/gnt/rvalid bus with at
// most one request outstanding, buffers returned words with their PCs, and restarts on
// redirect, discarding the response of any request issued before the redirect.
// Optional feature macro IFU_MISALIGN_CHECK_EN: a misaligned redirect raises a sticky
// fetch_fault and halts fetching until the next aligned redirect or reset. Without it,
// the redirect target's two low bits are ignored and fetch_fault is tied low.
module inst_fetch_unit
   import ifu_pkg::*;
#(
   parameter int unsigned  n        = IfuXlen,
   parameter int unsigned  DEPTH    = 4,
   parameter logic [n-1:0] RESET_PC = ResetPcDefault
) (
   input  logic               clk,
   input  logic               areset,
   input  logic               redirect,
   input  logic [n-1:0]       redirect_pc,
   inst_fetch_unit_if.master  bus,
   output logic               fetch_fault
);

   localparam int unsigned CntW = $clog2(DEPTH) + 1;

   ifu_state_e      state_q, state_d;
   logic [n-1:0]    fetch_pc_q, fetch_pc_d;
   logic [n-1:0]    req_pc_q, req_pc_d;
   logic            discard_q, discard_d;
   logic            fault_q, fault_d;

   logic [n-1:0]    target_pc;
   logic            target_misaligned;
   logic            rsp;
   logic            push;
   logic            pop;
   logic            space;
   ifu_entry_t      push_entry;
   ifu_entry_t      head;
   logic            head_valid;
   logic [CntW-1:0] count;

`ifdef IFU_MISALIGN_CHECK_EN
   assign target_pc         = redirect_pc;
   assign target_misaligned = (redirect_pc[1:0] != 2'b00);
   assign fetch_fault       = fault_q;
`else
   logic unused_redirect_lsb;
   assign unused_redirect_lsb = ^redirect_pc[1:0];
   assign target_pc           = {redirect_pc[n-1:2], 2'b00};
   assign target_misaligned   = 1'b0;
   assign fetch_fault         = 1'b0;
`endif

   // A response only counts while a request is outstanding; a redirect in the same cycle
   // drops it, and the core cannot pop from a FIFO that is being flushed
   assign rsp        = (state_q == StWait) && bus.mem_rvalid;
   assign push       = rsp && !discard_q && !redirect;
   assign pop        = head_valid && bus.instr_ready && !redirect;
   assign space      = redirect || ((count + CntW'(push)) < CntW'(DEPTH));
   assign push_entry = '{pc: req_pc_q, instr: bus.mem_rdata};

   ifu_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk    (clk),
      .areset (areset),
      .flush  (redirect),
      .push   (push),
      .wdata  (push_entry),
      .pop    (pop),
      .rdata  (head),
      .valid  (head_valid),
      .count  (count)
   );

   // Next-state: redirect bookkeeping first, then the request FSM
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      discard_d  = discard_q;
      fault_d    = fault_q;

      if (redirect) begin
         if (target_misaligned) begin
            fault_d = 1'b1;
         end else begin
            fault_d    = 1'b0;
            fetch_pc_d = target_pc;
         end
         // The in-flight response belongs to the old stream unless it is arriving right now
         if ((state_q == StReq) || ((state_q == StWait) && !bus.mem_rvalid)) begin
            discard_d = 1'b1;
         end
      end

      unique case (state_q)
         StIdle: begin
            // Wait one cycle after a redirect so the new target is the one requested
            if (!redirect && !fault_q && (count < CntW'(DEPTH))) begin
               state_d  = StReq;
               req_pc_d = fetch_pc_q;
            end
         end
         StReq: begin
            if (bus.mem_gnt) begin
               state_d = StWait;
               // After a redirect fetch_pc already holds the new target, not this request
               if (!discard_q && !redirect) begin
                  fetch_pc_d = fetch_pc_q + n'(4);
               end
            end
         end
         StWait: begin
            if (bus.mem_rvalid) begin
               if (discard_q) begin
                  discard_d = 1'b0;
               end
               if (!fault_d && space) begin
                  state_d  = StReq;
                  req_pc_d = fetch_pc_d;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers
   always_ff @(posedge clk) begin
      if (areset) begin
         state_q    <= StIdle;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= RESET_PC;
         discard_q  <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         discard_q  <= discard_d;
         fault_q    <= fault_d;
      end
   end

   assign bus.mem_req     = (state_q == StReq);
   assign bus.mem_addr    = req_pc_q;
   assign bus.instr_valid = head_valid;
   assign bus.instr       = head.instr;
   assign bus.instr_pc    = head.pc;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a memory model that grants after a
// programmable delay and answers one cycle after grant with rdata = addr ^ 32'hA5A5_0000.
module tb_inst_fetch_unit;

   logic        clk = 1'b0;
   logic        areset;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        fetch_fault;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          gnt_delay = 0;
   int          wait_cnt  = 0;
   logic [31:0] gnt_addr  = '0;

   inst_fetch_unit_if #(.n(32)) bus ();

   inst_fetch_unit #(
      .n        (32),
      .DEPTH    (4),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .areset      (areset),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .bus         (bus.master),
      .fetch_fault (fetch_fault)
   );

   always #5 clk = ~clk;

   // Memory model: respond the cycle after a grant, grant after gnt_delay request cycles
   always @(posedge clk) begin
      #1;
      if (bus.mem_gnt === 1'b1) begin
         bus.mem_rvalid = 1'b1;
         bus.mem_rdata  = gnt_addr ^ 32'hA5A5_0000;
      end else begin
         bus.mem_rvalid = 1'b0;
         bus.mem_rdata  = '0;
      end
      if (areset || (bus.mem_req !== 1'b1)) begin
         bus.mem_gnt = 1'b0;
         wait_cnt    = 0;
      end else if (wait_cnt >= gnt_delay) begin
         bus.mem_gnt = 1'b1;
         gnt_addr    = bus.mem_addr;
         wait_cnt    = 0;
      end else begin
         bus.mem_gnt = 1'b0;
         wait_cnt++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #2;
      cyc++;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Capture the next valid head (possibly the current one), then advance past it
   task automatic get_instr(input string tag, input int budget, output logic [31:0] pc,
                            output logic [31:0] ins, output int at);
      bit found = 1'b0;
      pc  = '0;
      ins = '0;
      at  = 0;
      for (int i = 0; i < budget && !found; i++) begin
         if (bus.instr_valid === 1'b1) begin
            pc    = bus.instr_pc;
            ins   = bus.instr;
            at    = cyc;
            found = 1'b1;
         end
         step();
      end
      n_tests++;
      assert (found === 1'b1) else begin
         n_fail++;
         $error("FAIL %s: got no instr_valid expected one within %0d cycles", tag, budget);
      end
   endtask

   // Ends in the first cycle with reset low
   task automatic do_reset();
      areset   = 1'b1;
      redirect = 1'b0;
      repeat (3) step();
      areset = 1'b0;
   endtask

   initial begin
      logic [31:0] pc;
      logic [31:0] ins;
      int          at;
      int          prev_at;
      bit          seen;

      areset          = 1'b1;
      redirect        = 1'b0;
      redirect_pc     = '0;
      bus.instr_ready = 1'b0;

      // Reset values
      repeat (3) step();
      check("rst_mem_req", 32'(bus.mem_req), 32'd0);
      check("rst_mem_addr", bus.mem_addr, 32'h0);
      check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
      check("rst_instr", bus.instr, 32'h0);
      check("rst_instr_pc", bus.instr_pc, 32'h0);
      check("rst_fetch_fault", 32'(fetch_fault), 32'd0);

      // Sequential fetch, zero-latency memory, core always ready
      areset          = 1'b0;
      bus.instr_ready = 1'b1;
      check("idle_after_reset", 32'(bus.mem_req), 32'd0);
      step();
      check("first_req", 32'(bus.mem_req), 32'd1);
      check("first_addr", bus.mem_addr, 32'h0);
      prev_at = 0;
      for (int k = 0; k < 4; k++) begin
         get_instr($sformatf("seq_wait%0d", k), 20, pc, ins, at);
         check($sformatf("seq_pc%0d", k), pc, 32'(k * 4));
         check($sformatf("seq_instr%0d", k), ins, 32'(k * 4) ^ 32'hA5A5_0000);
         if (k > 0) begin
            check($sformatf("seq_gap%0d", k), 32'(at - prev_at), 32'd2);
         end
         prev_at = at;
      end

      // Core stalled: exactly DEPTH entries fill, then no further requests
      bus.instr_ready = 1'b0;
      do_reset();
      repeat (20) step();
      check("fill_valid", 32'(bus.instr_valid), 32'd1);
      check("fill_head_pc", bus.instr_pc, 32'h0);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("fill_no_req%0d", k), 32'(bus.mem_req), 32'd0);
         step();
      end
      bus.instr_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         get_instr($sformatf("drain_wait%0d", k), 10, pc, ins, at);
         check($sformatf("drain_pc%0d", k), pc, 32'(k * 4));
         check($sformatf("drain_instr%0d", k), ins, 32'(k * 4) ^ 32'hA5A5_0000);
      end

      // Delayed grant holds the address; redirect during REQ discards the old word
      gnt_delay = 3;
      do_reset();
      step();
      check("dly_req", 32'(bus.mem_req), 32'd1);
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0100;
      step();
      redirect = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("dly_req_held%0d", k), 32'(bus.mem_req), 32'd1);
         check($sformatf("dly_addr_held%0d", k), bus.mem_addr, 32'h0);
         step();
      end
      get_instr("dly_redir_wait", 40, pc, ins, at);
      check("dly_redir_pc", pc, 32'h0000_0100);
      check("dly_redir_instr", ins, 32'hA5A5_0100);

      // Redirect in the same cycle as rvalid: that word never appears
      gnt_delay = 0;
      seen      = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (bus.mem_rvalid === 1'b1) begin
            seen = 1'b1;
         end else begin
            step();
         end
      end
      check("rv_found", 32'(seen), 32'd1);
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0200;
      step();
      redirect = 1'b0;
      check("rv_redir_flush", 32'(bus.instr_valid), 32'd0);
      get_instr("rv_redir_wait", 20, pc, ins, at);
      check("rv_redir_pc", pc, 32'h0000_0200);
      check("rv_redir_instr", ins, 32'hA5A5_0200);

      // Fetch address wraps at the top of the address space
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect = 1'b0;
      get_instr("wrap_wait0", 20, pc, ins, at);
      check("wrap_pc0", pc, 32'hFFFF_FFFC);
      check("wrap_instr0", ins, 32'h5A5A_FFFC);
      get_instr("wrap_wait1", 20, pc, ins, at);
      check("wrap_pc1", pc, 32'h0000_0000);
      check("wrap_instr1", ins, 32'hA5A5_0000);

      // Misaligned redirect
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0102;
      step();
      redirect = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
      check("mis_fault_set", 32'(fetch_fault), 32'd1);
      check("mis_flush", 32'(bus.instr_valid), 32'd0);
      repeat (6) step();
      for (int k = 0; k < 4; k++) begin
         check($sformatf("mis_halt_req%0d", k), 32'(bus.mem_req), 32'd0);
         check($sformatf("mis_halt_valid%0d", k), 32'(bus.instr_valid), 32'd0);
         step();
      end
      check("mis_fault_sticky", 32'(fetch_fault), 32'd1);
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0200;
      step();
      redirect = 1'b0;
      check("mis_fault_clear", 32'(fetch_fault), 32'd0);
      get_instr("mis_resume_wait", 20, pc, ins, at);
      check("mis_resume_pc", pc, 32'h0000_0200);
      check("mis_resume_instr", ins, 32'hA5A5_0200);
`else
      check("mis_no_fault", 32'(fetch_fault), 32'd0);
      get_instr("mis_align_wait", 20, pc, ins, at);
      check("mis_align_pc", pc, 32'h0000_0100);
      check("mis_align_instr", ins, 32'hA5A5_0100);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
